// File: rtl/water_level_monitor_mc.sv
// Multi-channel water level monitor: per-channel debounced, hysteretic NORMAL/WARN/ALARM/ACKED
// classification plus registered summary flags. Define WD_ALARM_LATCH_EN to latch ALARM until ack.

module water_level_ch #(
  parameter int LVL_W    = 8,
  parameter int WARN_TH  = 60,
  parameter int ALARM_TH = 80,
  parameter int HYST     = 5,
  parameter int DEB_CYC  = 1000
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr,
  input  logic [LVL_W-1:0] i_level,
  input  logic             i_ack,
  output logic [1:0]       o_state
);
  typedef enum logic [1:0] {ST_NORMAL = 2'd0, ST_WARN = 2'd1, ST_ALARM = 2'd2, ST_ACKED = 2'd3} state_t;

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [LVL_W-1:0] A_HI = LVL_W'(ALARM_TH);
  localparam logic [LVL_W-1:0] A_LO = LVL_W'(ALARM_TH - HYST);
  localparam logic [LVL_W-1:0] W_HI = LVL_W'(WARN_TH);
  localparam logic [LVL_W-1:0] W_LO = LVL_W'(WARN_TH - HYST);
  localparam logic [CNT_W-1:0] DEB_M1  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [LVL_W-1:0] r_level;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       w_cur_cls;
  logic [1:0]       w_tgt_cls;

  // Class codes 0/1/2 coincide with the NORMAL/WARN/ALARM state codes.
  always_comb begin
    w_cur_cls = 2'd0;
    if (r_state == ST_ALARM || r_state == ST_ACKED) w_cur_cls = 2'd2;
    else if (r_state == ST_WARN)                    w_cur_cls = 2'd1;

    w_tgt_cls = 2'd0;
    if (r_level >= A_HI)                             w_tgt_cls = 2'd2;
    else if (w_cur_cls == 2'd2 && r_level >= A_LO)   w_tgt_cls = 2'd2;
    else if (r_level >= W_HI)                        w_tgt_cls = 2'd1;
    else if (w_cur_cls != 2'd0 && r_level >= W_LO)   w_tgt_cls = 2'd1;
`ifdef WD_ALARM_LATCH_EN
    if (r_state == ST_ALARM) w_tgt_cls = 2'd2;
`else
`endif
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_level <= '0;
      r_state <= ST_NORMAL;
      r_cnt   <= '0;
    end else begin
      if (i_wr) r_level <= i_level;
      if (w_tgt_cls == w_cur_cls) begin
        r_cnt <= '0;
        if (i_ack && r_state == ST_ALARM) r_state <= ST_ACKED;
      end else if (r_cnt == DEB_M1) begin
        // Debounced transition takes precedence over a coincident ack.
        r_cnt   <= '0;
        r_state <= state_t'(w_tgt_cls);
      end else begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        if (i_ack && r_state == ST_ALARM) r_state <= ST_ACKED;
      end
    end
  end

  assign o_state = r_state;
endmodule

module water_level_monitor_mc #(
  parameter int N_CH     = 4,
  parameter int LVL_W    = 8,
  parameter int WARN_TH  = 60,
  parameter int ALARM_TH = 80,
  parameter int HYST     = 5,
  parameter int DEB_CYC  = 1000,
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_level_valid,
  input  logic [CH_W-1:0]   i_level_ch,
  input  logic [LVL_W-1:0]  i_level_in,
  input  logic              i_ack,
  output logic [2*N_CH-1:0] o_ch_state,
  output logic              o_warn_any,
  output logic              o_alarm_any,
  output logic              o_beep_en,
  output logic [CH_W-1:0]   o_worst_ch
);
  logic [N_CH-1:0][1:0] w_state;

  // Channels outside 0..N_CH-1 never match a write select, so such writes drop.
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    water_level_ch #(
      .LVL_W(LVL_W), .WARN_TH(WARN_TH), .ALARM_TH(ALARM_TH), .HYST(HYST), .DEB_CYC(DEB_CYC)
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_wr    (i_level_valid && (i_level_ch == CH_W'(g))),
      .i_level (i_level_in),
      .i_ack   (i_ack),
      .o_state (w_state[g])
    );
  end

  assign o_ch_state = w_state;

  logic            w_warn, w_alarm, w_beep;
  logic [1:0]      w_rank, w_best;
  logic [CH_W-1:0] w_worst;

  // Rank ALARM > ACKED > WARN > NORMAL; strict compare keeps the lowest index on ties.
  always_comb begin
    w_warn  = 1'b0;
    w_alarm = 1'b0;
    w_beep  = 1'b0;
    w_rank  = 2'd0;
    w_best  = 2'd0;
    w_worst = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (w_state[i])
        2'd1:    w_rank = 2'd1;
        2'd2:    w_rank = 2'd3;
        2'd3:    w_rank = 2'd2;
        default: w_rank = 2'd0;
      endcase
      if (w_state[i] == 2'd1) w_warn  = 1'b1;
      if (w_state[i][1])      w_alarm = 1'b1;
      if (w_state[i] == 2'd2) w_beep  = 1'b1;
      if (w_rank > w_best) begin
        w_best  = w_rank;
        w_worst = CH_W'(i);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_warn_any  <= 1'b0;
      o_alarm_any <= 1'b0;
      o_beep_en   <= 1'b0;
      o_worst_ch  <= '0;
    end else begin
      o_warn_any  <= w_warn;
      o_alarm_any <= w_alarm;
      o_beep_en   <= w_beep;
      o_worst_ch  <= w_worst;
    end
  end
endmodule
